// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback plus ALU decoder.
// Optional jal support is enabled by defining MC_JAL_EN.
module mips_multicycle_ctrl #(
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           RegDst,
  output logic [1:0]           Memtoreg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 pc_en,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic [STATE_W-1:0]   state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
`ifdef MC_JAL_EN
    , JALEX
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       iord, mem_write, ir_write, reg_write, alu_src_a;
  logic       pc_write, branch, done, illegal;
  logic [1:0] reg_dst, memtoreg, alu_src_b, pc_src;
  logic [2:0] alu_ctrl, funct_alu;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    case (funct)
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = FETCH;
    iord      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 2'b00;
    memtoreg  = 2'b00;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctrl  = 3'b000;
    pc_src    = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MC_JAL_EN
          OP_JAL:       state_d = JALEX;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg  = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      MEMWR: begin
        // Strobe stays up across wait cycles; the access retires on mem_ready.
        iord      = 1'b1;
        mem_write = 1'b1;
        done      = mem_ready;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        done      = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done     = 1'b1;
      end
`ifdef MC_JAL_EN
      JALEX: begin
        // Register file captures the current PC (already PC+4) as the link address.
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        reg_dst   = 2'b10;
        memtoreg  = 2'b10;
        reg_write = 1'b1;
        done      = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu_ctrl;
  end

  // Strobes are held low while reset is asserted; selects already show FETCH values.
  assign IorD       = iord;
  assign MemWrite   = mem_write & ~reset;
  assign IRWrite    = ir_write & ~reset;
  assign RegDst     = reg_dst;
  assign Memtoreg   = memtoreg;
  assign RegWrite   = reg_write & ~reset;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign PCSrc      = pc_src;
  assign pc_en      = (pc_write | (branch & zero)) & ~reset;
  assign instr_done = done & ~reset;
  assign illegal_op = illegal & ~reset;
  assign state      = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit: a Moore state machine plus ALU decoder that sequences fetch, decode, execute, memory and writeback over several cycles for a shared-memory, single-ALU datapath. It sits beside the multicycle datapath and drives every mux select, write enable and ALU operation. Memory accesses stall on a ready handshake. A one-cycle pulse marks each completed instruction.

## Interface
- ALUCTRL_W, 3: ALU control width, ≥3; bits above [2:0] are driven 0.
- STATE_W, 4: state register width, ≥4.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces state to FETCH.
- op  input  6  instruction[31:26] from the instruction register.
- funct  input  6  instruction[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- RegDst  output  2  write register: 00 rt, 01 rd, 10 $31.
- Memtoreg  output  2  write data: 00 ALUOut, 01 data register, 10 PC.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- ALUControl  output  ALUCTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target.
- pc_en  output  1  PCWrite | (Branch & zero).
- instr_done  output  1  one-cycle pulse on an instruction's final cycle.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  output  STATE_W  current state, for debug.

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
  - jal 000011 (macro-gated)
- States:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, JALEX 12.
  - Encodings 13..max are unreachable; if entered, next state is FETCH.
- FETCH:
  - Drives IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, add.
  - Dispatch: lw/sw → MEMADR; R → RTYPEEX; beq → BEQEX; addi → ADDIEX; j → JEX; jal → JALEX.
  - Any other opcode → FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add; then lw → MEMRD, sw → MEMWR.
- MEMRD: IorD=1; waits for mem_ready, then → MEMWB.
- MEMWB: RegDst=00, Memtoreg=01, RegWrite=1; → FETCH.
- MEMWR: IorD=1; MemWrite held high while waiting; → FETCH when mem_ready=1.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUControl from funct; → RTYPEWB.
  - Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct → add.
- RTYPEWB: RegDst=01, Memtoreg=00, RegWrite=1; → FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1; → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add; → ADDIWB.
- ADDIWB: RegDst=00, Memtoreg=00, RegWrite=1; → FETCH.
- JEX: PCSrc=10, PCWrite=1; → FETCH.
- JALEX: PCSrc=10, PCWrite=1, RegDst=10, Memtoreg=10, RegWrite=1; → FETCH.
  - Register file samples PC before the update, i.e. PC+4.
- Defaults: any output not listed for a state is 0.
- instr_done is 1 in:
  - MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX, JALEX;
  - MEMWR only when mem_ready=1.
- All outputs are combinational from state; IRWrite, PCWrite, MemWrite-completion and instr_done also depend on mem_ready.

## Timing
- Reset:
  - state=FETCH asynchronously.
  - While reset=1, MemWrite, IRWrite, RegWrite, pc_en, instr_done and illegal_op are forced to 0.
  - Mux selects show their FETCH values: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, RegDst=00, Memtoreg=00.
- Reset during any state, including a memory wait, abandons the instruction; no further strobes occur.
- Minimum cycles with mem_ready tied high:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3, jal 3.
- Each memory wait cycle adds one cycle to that state.
- Branch not taken: zero=0 in BEQEX gives pc_en=0; the PC keeps the FETCH-incremented value.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Configuration
- MC_JAL_EN defined: opcode 000011 dispatches to JALEX.
- MC_JAL_EN undefined:
  - JALEX does not exist; 000011 is illegal (illegal_op pulse, → FETCH).
  - RegDst and Memtoreg never drive 10.

## Test plan
- Reset mid-MEMRD, with mem_ready=0 → state=0 immediately, all strobes 0, then a normal FETCH.
- mem_ready=1 throughout; op=000000, funct=100010 → states 0,1,6,7; ALUControl=110 in RTYPEEX; RegWrite=1, RegDst=01 in RTYPEWB; instr_done on cycle 4.
- op=100011 with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4; Memtoreg=01 in MEMWB; 7 cycles total.
- op=000100, zero=1 → pc_en=1 in BEQEX, PCSrc=01; with zero=0 → pc_en=0.
- op=101011 with mem_ready=0 for 1 cycle in MEMWR → MemWrite high 2 cycles; instr_done only on the second.
- op=000011:
  - with MC_JAL_EN → JALEX, RegDst=10, Memtoreg=10, RegWrite=1, pc_en=1;
  - without MC_JAL_EN → illegal_op=1 in DECODE, next state 0.
